mips_mc_controller: RTL and testbench
=====================================

# mips_mc_controller

Next-generation multi-cycle MIPS control unit: a Moore-style main FSM with ALU decode that drives the existing multi-cycle datapath. Unlike the previous controller, it handles a variable-latency memory through a req/ready handshake and supports bne/andi/ori when `EXT_OPS=1`. It detects illegal opcodes and functs, and has an optional memory-timeout watchdog. It sits in the `mips` top between the instruction register fields and the datapath control inputs.

## Interface
- `EXT_OPS`, 1, enables bne/andi/ori decode; 0 makes those opcodes illegal
- `TIMEOUT_CYCLES`, 0, maximum wait cycles per memory access; 0 disables the watchdog
- `clk` in 1 clock, all state on the rising edge
- `reset` in 1 asynchronous, active-low reset
- `op` in 6 instr[31:26]
- `funct` in 6 instr[5:0]
- `zero` in 1 ALU zero flag from the datapath
- `mem_ready` in 1 memory completes the current access this cycle
- `mem_req` out 1 memory access request
- `memwrite` out 1 request is a write (valid only with `mem_req`)
- `iord` out 1 address select: 0 = PC, 1 = ALUOut
- `irwrite` out 1 instruction register load
- `pcen` out 1 PC load enable
- `regwrite` out 1 register file write
- `regdst` out 1 1 = rd, 0 = rt
- `memtoreg` out 1 1 = data register, 0 = ALUOut
- `alusrca` out 1 0 = PC, 1 = register A
- `alusrcb` out 2 00 = B, 01 = 4, 10 = immediate, 11 = immediate<<2
- `zeroext` out 1 immediate is zero-extended (andi/ori)
- `pcsrc` out 2 00 = ALU result, 01 = ALUOut, 10 = jump target
- `alucontrol` out 3 010 add, 110 sub, 000 and, 001 or, 111 slt
- `fault` out 1 sticky fault flag
- `fault_code` out 2 01 = illegal instruction, 10 = memory timeout

## Operation
- States: BOOT, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, IMMEX, IMMWB, JUMP, FAULT.
- Outputs default to 0 in every state unless listed; alucontrol defaults to 010.
- BOOT: all outputs 0; next state FETCH.
- FETCH:
  - mem_req=1, iord=0, alusrca=0, alusrcb=01, pcsrc=00.
  - irwrite and pcen equal mem_ready.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: alusrca=0, alusrcb=11 (branch target into ALUOut). Next state by op:
  - lw/sw (100011/101011) -> MEMADR
  - R-type (000000) with a legal funct -> EXEC
  - beq (000100) -> BRANCH
  - bne (000101) -> BRANCH if EXT_OPS
  - addi (001000) -> IMMEX
  - andi/ori (001100/001101) -> IMMEX if EXT_OPS
  - j (000010) -> JUMP
  - anything else -> FAULT with code 01
- Legal R-type functs: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Any other funct is a fault with code 01.
- MEMADR: alusrca=1, alusrcb=10; next state MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1; waits for mem_ready, then MEMWB.
- MEMWB: regwrite=1, regdst=0, memtoreg=1; next state FETCH.
- MEMWR: mem_req=1, memwrite=1, iord=1; waits for mem_ready, then FETCH.
- EXEC: alusrca=1, alusrcb=00, alucontrol from funct; next state ALUWB.
- ALUWB: regwrite=1, regdst=1, memtoreg=0; next state FETCH.
- BRANCH: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01. pcen = zero for beq, ~zero for bne. Next state FETCH.
- IMMEX: alusrca=1, alusrcb=10.
  - addi: alucontrol 010.
  - andi: alucontrol 000, zeroext=1.
  - ori: alucontrol 001, zeroext=1.
  - Next state IMMWB.
- IMMWB: regwrite=1, regdst=0, memtoreg=0; next state FETCH.
- JUMP: pcsrc=10, pcen=1; next state FETCH.
- FAULT: all control outputs 0, fault=1, fault_code held. Only reset leaves FAULT.
- Watchdog (TIMEOUT_CYCLES > 0):
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
  - Counter clears on entry to FETCH, MEMRD and MEMWR.
  - It increments on each wait cycle with mem_ready=0.
  - When the count reaches TIMEOUT_CYCLES with mem_ready still 0, the FSM goes to FAULT with code 10.
  - mem_ready on that same cycle wins: the access completes normally.

## Timing
- Reset (reset=0, asynchronous): state=BOOT, watchdog counter=0, fault=0, fault_code=00. Every output is 0 and alucontrol=010.
- All outputs are combinational from the state register, plus mem_ready (irwrite/pcen in FETCH), zero and op (pcen in BRANCH), and op/funct (alucontrol, zeroext). No output is registered.
- The memory handshake completes on the cycle where mem_req && mem_ready. mem_ready outside a memory state is ignored.
- Zero-wait-state memory gives these cycle counts, including fetch:
  - lw: 5
  - sw: 4
  - R-type: 4
  - addi/andi/ori: 4
  - beq/bne: 3
  - j: 3
- Each wait cycle adds 1 to the count.
- Reset asserted mid-access drops mem_req asynchronously. After release, the FSM spends one cycle in BOOT, then FETCH.

## Structure
- Package `mips_mc_pkg`: state enum, opcode and funct constants, alucontrol and fault_code constants.
- Sub-module `mips_aludec`: combinational mapping of op/funct/state class to alucontrol, zeroext and the funct-legal flag.
- The FSM, watchdog and output decode live in `mips_mc_controller`.

## Test plan
- Reset release, FETCH held 3 cycles with mem_ready=0, then 1 -> irwrite and pcen pulse only on the ready cycle; DECODE follows.
- Instruction sequence lw, sw, add, addi with mem_ready tied to 1 -> 5/4/4/4 cycles. Check regdst/memtoreg/regwrite per writeback state.
- beq with zero=1 and bne with zero=1 (EXT_OPS=1) -> beq gives pcen=1 with pcsrc=01; bne gives pcen=0.
- Illegal cases, op=111111 or R-type funct=000000 -> FAULT, fault=1, fault_code=01, held until reset.
- Watchdog with TIMEOUT_CYCLES=4 and mem_ready low in MEMRD -> FAULT with code 10 after 4 wait cycles. mem_ready on the 4th wait cycle -> normal MEMWB instead.
- EXT_OPS=0, ori opcode -> FAULT with code 01; andi with EXT_OPS=1 -> zeroext=1 and alucontrol=000 in IMMEX.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, opcodes,
// R-type functs, ALU operations and fault codes.
package mips_mc_pkg;

    localparam logic [3:0] StBoot   = 4'd0;
    localparam logic [3:0] StFetch  = 4'd1;
    localparam logic [3:0] StDecode = 4'd2;
    localparam logic [3:0] StMemAdr = 4'd3;
    localparam logic [3:0] StMemRd  = 4'd4;
    localparam logic [3:0] StMemWb  = 4'd5;
    localparam logic [3:0] StMemWr  = 4'd6;
    localparam logic [3:0] StExec   = 4'd7;
    localparam logic [3:0] StAluWb  = 4'd8;
    localparam logic [3:0] StBranch = 4'd9;
    localparam logic [3:0] StImmEx  = 4'd10;
    localparam logic [3:0] StImmWb  = 4'd11;
    localparam logic [3:0] StJump   = 4'd12;
    localparam logic [3:0] StFault  = 4'd13;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;

    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluSlt = 3'b111;

    localparam logic [1:0] FaultNone    = 2'b00;
    localparam logic [1:0] FaultIllegal = 2'b01;
    localparam logic [1:0] FaultTimeout = 2'b10;

    // Which source drives the ALU operation in the current state.
    typedef enum logic [1:0] {
        AluClsAdd,
        AluClsFunct,
        AluClsImm,
        AluClsSub
    } alu_cls_e;

endpackage

// File: rtl/mips_aludec.sv
// ALU decoder: maps op/funct and the state's ALU class to alucontrol and
// zeroext, and flags whether the R-type funct is one we implement.
module mips_aludec
    import mips_mc_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  alu_cls_e   cls_i,
    output logic [2:0] alucontrol_o,
    output logic       zeroext_o,
    output logic       funct_legal_o
);

    logic [2:0] funct_alu;
    logic [2:0] imm_alu;
    logic       imm_zext;

    always_comb begin
        funct_legal_o = 1'b1;
        funct_alu     = AluAdd;
        case (funct_i)
            FnAdd:   funct_alu = AluAdd;
            FnSub:   funct_alu = AluSub;
            FnAnd:   funct_alu = AluAnd;
            FnOr:    funct_alu = AluOr;
            FnSlt:   funct_alu = AluSlt;
            default: funct_legal_o = 1'b0;
        endcase
    end

    always_comb begin
        imm_alu  = AluAdd;
        imm_zext = 1'b0;
        case (op_i)
            OpAndi: begin
                imm_alu  = AluAnd;
                imm_zext = 1'b1;
            end
            OpOri: begin
                imm_alu  = AluOr;
                imm_zext = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        alucontrol_o = AluAdd;
        zeroext_o    = 1'b0;
        case (cls_i)
            AluClsFunct: alucontrol_o = funct_alu;
            AluClsSub:   alucontrol_o = AluSub;
            AluClsImm: begin
                alucontrol_o = imm_alu;
                zeroext_o    = imm_zext;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control FSM with req/ready memory handshake, illegal
// instruction detection and an optional memory-wait watchdog.
module mips_mc_controller
    import mips_mc_pkg::*;
#(
    parameter bit          EXT_OPS        = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       memwrite_o,
    output logic       iord_o,
    output logic       irwrite_o,
    output logic       pcen_o,
    output logic       regwrite_o,
    output logic       regdst_o,
    output logic       memtoreg_o,
    output logic       alusrca_o,
    output logic [1:0] alusrcb_o,
    output logic       zeroext_o,
    output logic [1:0] pcsrc_o,
    output logic [2:0] alucontrol_o,
    output logic       fault_o,
    output logic [1:0] fault_code_o
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Count value on the wait cycle that would make the total reach the limit.
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [3:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      fault_code_q, fault_code_d;
    logic [3:0]      decode_next;
    logic            funct_legal;
    logic            mem_state;
    logic            timeout;
    alu_cls_e        alu_cls;

    mips_aludec u_aludec (
        .op_i          (op_i),
        .funct_i       (funct_i),
        .cls_i         (alu_cls),
        .alucontrol_o  (alucontrol_o),
        .zeroext_o     (zeroext_o),
        .funct_legal_o (funct_legal)
    );

    always_comb begin
        decode_next = StFault;
        case (op_i)
            OpLw, OpSw:    decode_next = StMemAdr;
            OpRtype:       decode_next = funct_legal ? StExec : StFault;
            OpBeq:         decode_next = StBranch;
            OpBne:         decode_next = EXT_OPS ? StBranch : StFault;
            OpAddi:        decode_next = StImmEx;
            OpAndi, OpOri: decode_next = EXT_OPS ? StImmEx : StFault;
            OpJ:           decode_next = StJump;
            default:       decode_next = StFault;
        endcase
    end

    assign mem_state = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
    // A ready on the limiting cycle completes the access instead of faulting.
    assign timeout = (TIMEOUT_CYCLES != 0) && mem_state && !mem_ready_i && (cnt_q == CntLast);

    always_comb begin
        state_d      = state_q;
        fault_code_d = fault_code_q;
        cnt_d        = '0;
        if (mem_state && !mem_ready_i) begin
            cnt_d = cnt_q + 1'b1;
        end
        case (state_q)
            StBoot:   state_d = StFetch;
            StFetch:  if (mem_ready_i) state_d = StDecode;
            StDecode: begin
                state_d = decode_next;
                if (decode_next == StFault) begin
                    fault_code_d = FaultIllegal;
                end
            end
            StMemAdr: state_d = (op_i == OpLw) ? StMemRd : StMemWr;
            StMemRd:  if (mem_ready_i) state_d = StMemWb;
            StMemWb:  state_d = StFetch;
            StMemWr:  if (mem_ready_i) state_d = StFetch;
            StExec:   state_d = StAluWb;
            StAluWb:  state_d = StFetch;
            StBranch: state_d = StFetch;
            StImmEx:  state_d = StImmWb;
            StImmWb:  state_d = StFetch;
            StJump:   state_d = StFetch;
            StFault:  state_d = StFault;
            default:  state_d = StBoot;
        endcase
        if (timeout) begin
            state_d      = StFault;
            fault_code_d = FaultTimeout;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StBoot;
            cnt_q        <= '0;
            fault_code_q <= FaultNone;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fault_code_q <= fault_code_d;
        end
    end

    always_comb begin
        mem_req_o  = 1'b0;
        memwrite_o = 1'b0;
        iord_o     = 1'b0;
        irwrite_o  = 1'b0;
        pcen_o     = 1'b0;
        regwrite_o = 1'b0;
        regdst_o   = 1'b0;
        memtoreg_o = 1'b0;
        alusrca_o  = 1'b0;
        alusrcb_o  = 2'b00;
        pcsrc_o    = 2'b00;
        alu_cls    = AluClsAdd;
        case (state_q)
            StFetch: begin
                mem_req_o = 1'b1;
                alusrcb_o = 2'b01;
                irwrite_o = mem_ready_i;
                pcen_o    = mem_ready_i;
            end
            StDecode: alusrcb_o = 2'b11;
            StMemAdr: begin
                alusrca_o = 1'b1;
                alusrcb_o = 2'b10;
            end
            StMemRd: begin
                mem_req_o = 1'b1;
                iord_o    = 1'b1;
            end
            StMemWb: begin
                regwrite_o = 1'b1;
                memtoreg_o = 1'b1;
            end
            StMemWr: begin
                mem_req_o  = 1'b1;
                memwrite_o = 1'b1;
                iord_o     = 1'b1;
            end
            StExec: begin
                alusrca_o = 1'b1;
                alu_cls   = AluClsFunct;
            end
            StAluWb: begin
                regwrite_o = 1'b1;
                regdst_o   = 1'b1;
            end
            StBranch: begin
                alusrca_o = 1'b1;
                alu_cls   = AluClsSub;
                pcsrc_o   = 2'b01;
                pcen_o    = (op_i == OpBne) ? ~zero_i : zero_i;
            end
            StImmEx: begin
                alusrca_o = 1'b1;
                alusrcb_o = 2'b10;
                alu_cls   = AluClsImm;
            end
            StImmWb: regwrite_o = 1'b1;
            StJump: begin
                pcsrc_o = 2'b10;
                pcen_o  = 1'b1;
            end
            default: ;
        endcase
    end

    assign fault_o      = (state_q == StFault);
    assign fault_code_o = fault_code_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Scoreboard bench: stimulus pushes the per-cycle control word each instruction
// should produce; a negedge monitor pops and compares against two DUT configurations.
module tb_mips_mc_controller;

    typedef struct packed {
        logic       mem_req;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       pcen;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       zeroext;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
        logic       fault;
        logic [1:0] fault_code;
    } ctl_t;

    typedef enum int {KLw, KSw, KR, KBr, KImm, KJ, KIll} kind_e;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, ANDI = 6'b001100;
    localparam logic [5:0] ORI = 6'b001101, JMP = 6'b000010;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic a_mem_req, a_memwrite, a_iord, a_irwrite, a_pcen, a_regwrite, a_regdst, a_memtoreg;
    logic a_alusrca, a_zeroext, a_fault;
    logic [1:0] a_alusrcb, a_pcsrc, a_fault_code;
    logic [2:0] a_alucontrol;
    logic b_mem_req, b_memwrite, b_iord, b_irwrite, b_pcen, b_regwrite, b_regdst, b_memtoreg;
    logic b_alusrca, b_zeroext, b_fault;
    logic [1:0] b_alusrcb, b_pcsrc, b_fault_code;
    logic [2:0] b_alucontrol;

    ctl_t act_a, act_b;
    ctl_t q_a[$], q_b[$];
    string n_a[$], n_b[$];
    ctl_t exp_c;
    string exp_n;
    int n_checks = 0;
    int n_fail = 0;
    logic chk_end = 1'b0;

    always #5 clk = ~clk;

    mips_mc_controller #(.EXT_OPS(1'b1), .TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .op_i(op), .funct_i(funct), .zero_i(zero),
        .mem_ready_i(mem_ready), .mem_req_o(a_mem_req), .memwrite_o(a_memwrite),
        .iord_o(a_iord), .irwrite_o(a_irwrite), .pcen_o(a_pcen), .regwrite_o(a_regwrite),
        .regdst_o(a_regdst), .memtoreg_o(a_memtoreg), .alusrca_o(a_alusrca),
        .alusrcb_o(a_alusrcb), .zeroext_o(a_zeroext), .pcsrc_o(a_pcsrc),
        .alucontrol_o(a_alucontrol), .fault_o(a_fault), .fault_code_o(a_fault_code)
    );

    mips_mc_controller #(.EXT_OPS(1'b0), .TIMEOUT_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .op_i(op), .funct_i(funct), .zero_i(zero),
        .mem_ready_i(mem_ready), .mem_req_o(b_mem_req), .memwrite_o(b_memwrite),
        .iord_o(b_iord), .irwrite_o(b_irwrite), .pcen_o(b_pcen), .regwrite_o(b_regwrite),
        .regdst_o(b_regdst), .memtoreg_o(b_memtoreg), .alusrca_o(b_alusrca),
        .alusrcb_o(b_alusrcb), .zeroext_o(b_zeroext), .pcsrc_o(b_pcsrc),
        .alucontrol_o(b_alucontrol), .fault_o(b_fault), .fault_code_o(b_fault_code)
    );

    assign act_a = {a_mem_req, a_memwrite, a_iord, a_irwrite, a_pcen, a_regwrite, a_regdst,
                    a_memtoreg, a_alusrca, a_alusrcb, a_zeroext, a_pcsrc, a_alucontrol,
                    a_fault, a_fault_code};
    assign act_b = {b_mem_req, b_memwrite, b_iord, b_irwrite, b_pcen, b_regwrite, b_regdst,
                    b_memtoreg, b_alusrca, b_alusrcb, b_zeroext, b_pcsrc, b_alucontrol,
                    b_fault, b_fault_code};

    // Monitor: one expected control word per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (q_a.size() > 0) begin
            exp_c = q_a.pop_front();
            exp_n = n_a.pop_front();
            n_checks++;
            if (act_a !== exp_c) begin
                n_fail++;
                $display("FAIL %s: got %h, want %h (t=%0t)", exp_n, act_a, exp_c, $time);
            end
        end
        if (q_b.size() > 0) begin
            exp_c = q_b.pop_front();
            exp_n = n_b.pop_front();
            n_checks++;
            if (act_b !== exp_c) begin
                n_fail++;
                $display("FAIL dut0 %s: got %h, want %h (t=%0t)", exp_n, act_b, exp_c, $time);
            end
        end
        if (chk_end) begin
            n_checks++;
            if (q_a.size() != 0 || q_b.size() != 0) begin
                n_fail++;
                $display("FAIL drain: got %0d/%0d entries left, want 0/0", q_a.size(), q_b.size());
            end
        end
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic ctl_t idle();
        ctl_t c = '0;
        c.alucontrol = 3'b010;
        return c;
    endfunction

    function automatic ctl_t fetch_e(input logic rdy);
        ctl_t c = idle();
        c.mem_req = 1'b1;
        c.alusrcb = 2'b01;
        c.irwrite = rdy;
        c.pcen    = rdy;
        return c;
    endfunction

    function automatic ctl_t fault_e(input logic [1:0] code);
        ctl_t c = idle();
        c.fault      = 1'b1;
        c.fault_code = code;
        return c;
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            default:   return 3'b111;
        endcase
    endfunction

    function automatic kind_e kind_of(input logic [5:0] o, input logic [5:0] f);
        case (o)
            LW:             return KLw;
            SW:             return KSw;
            RT:             return (f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                              6'b101010}) ? KR : KIll;
            BEQ, BNE:       return KBr;
            ADDI, ANDI, ORI: return KImm;
            JMP:            return KJ;
            default:        return KIll;
        endcase
    endfunction

    task automatic step(input logic [5:0] o, input logic [5:0] f, input logic rdy,
                        input logic z, input ctl_t e, input string n);
        @(posedge clk);
        #1;
        op        = o;
        funct     = f;
        mem_ready = rdy;
        zero      = z;
        q_a.push_back(e);
        n_a.push_back(n);
    endtask

    task automatic step2(input logic [5:0] o, input logic [5:0] f, input logic rdy,
                         input logic z, input ctl_t e, input ctl_t e0, input string n);
        step(o, f, rdy, z, e, n);
        q_b.push_back(e0);
        n_b.push_back(n);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        q_a.push_back(idle()); n_a.push_back("reset");
        q_b.push_back(idle()); n_b.push_back("reset");
        step2(op, funct, 1'b0, 1'b0, idle(), idle(), "reset_hold");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q_a.push_back(idle()); n_a.push_back("boot");
        q_b.push_back(idle()); n_b.push_back("boot");
    endtask

    // Fetch through completion of one instruction; illegal ones leave the DUT in FAULT.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int wf, input int wm);
        ctl_t  e;
        kind_e k = kind_of(o, f);
        for (int i = 0; i < wf; i++) step(o, f, 1'b0, rb(), fetch_e(1'b0), "fetch_wait");
        step(o, f, 1'b1, rb(), fetch_e(1'b1), "fetch_ready");
        e = idle(); e.alusrcb = 2'b11;
        step(o, f, rb(), rb(), e, "decode");
        case (k)
            KLw, KSw: begin
                e = idle(); e.alusrca = 1'b1; e.alusrcb = 2'b10;
                step(o, f, rb(), rb(), e, "memadr");
                e = idle(); e.mem_req = 1'b1; e.iord = 1'b1; e.memwrite = (k == KSw);
                for (int i = 0; i < wm; i++) step(o, f, 1'b0, rb(), e, "mem_wait");
                step(o, f, 1'b1, rb(), e, "mem_ready");
                if (k == KLw) begin
                    e = idle(); e.regwrite = 1'b1; e.memtoreg = 1'b1;
                    step(o, f, rb(), rb(), e, "memwb");
                end
            end
            KR: begin
                e = idle(); e.alusrca = 1'b1; e.alucontrol = funct_alu(f);
                step(o, f, rb(), rb(), e, "exec");
                e = idle(); e.regwrite = 1'b1; e.regdst = 1'b1;
                step(o, f, rb(), rb(), e, "aluwb");
            end
            KImm: begin
                e = idle(); e.alusrca = 1'b1; e.alusrcb = 2'b10;
                e.alucontrol = (o == ANDI) ? 3'b000 : (o == ORI) ? 3'b001 : 3'b010;
                e.zeroext = (o != ADDI);
                step(o, f, rb(), rb(), e, "immex");
                e = idle(); e.regwrite = 1'b1;
                step(o, f, rb(), rb(), e, "immwb");
            end
            KBr: begin
                e = idle(); e.alusrca = 1'b1; e.alucontrol = 3'b110; e.pcsrc = 2'b01;
                e.pcen = (o == BNE) ? ~z : z;
                step(o, f, rb(), z, e, "branch");
            end
            KJ: begin
                e = idle(); e.pcsrc = 2'b10; e.pcen = 1'b1;
                step(o, f, rb(), rb(), e, "jump");
            end
            default: begin
                for (int i = 0; i < 3; i++) step(o, f, rb(), rb(), fault_e(2'b01), "illegal");
            end
        endcase
    endtask

    initial begin
        logic [5:0] ro, rf;
        logic [5:0] fn_tab [0:4];
        logic [5:0] op_tab [0:8];
        ctl_t e, e0;
        fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        op_tab = '{LW, SW, RT, BEQ, BNE, ADDI, ANDI, ORI, JMP};

        do_reset();
        run_instr(LW, 6'h0, 1'b0, 3, 0);
        run_instr(SW, 6'h0, 1'b0, 0, 0);
        run_instr(RT, 6'b100000, 1'b0, 0, 0);
        run_instr(ADDI, 6'h0, 1'b0, 0, 0);
        run_instr(BEQ, 6'h0, 1'b1, 0, 0);
        run_instr(BNE, 6'h0, 1'b1, 0, 0);
        run_instr(BNE, 6'h0, 1'b0, 0, 0);
        run_instr(BEQ, 6'h0, 1'b0, 0, 0);
        run_instr(ANDI, 6'h0, 1'b0, 0, 0);
        run_instr(ORI, 6'h0, 1'b0, 1, 0);
        run_instr(JMP, 6'h0, 1'b0, 0, 0);
        run_instr(LW, 6'h0, 1'b0, 0, 3);
        run_instr(SW, 6'h0, 1'b0, 2, 3);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                ro = 6'($urandom);
                rf = 6'($urandom);
            end else begin
                ro = op_tab[$urandom_range(0, 8)];
                rf = fn_tab[$urandom_range(0, 4)];
            end
            run_instr(ro, rf, rb(), $urandom_range(0, 3), $urandom_range(0, 3));
            if (kind_of(ro, rf) == KIll) do_reset();
        end

        // Reset in the middle of a load's memory wait.
        step(LW, 6'h0, 1'b1, 1'b0, fetch_e(1'b1), "mid_fetch");
        e = idle(); e.alusrcb = 2'b11;
        step(LW, 6'h0, 1'b0, 1'b0, e, "mid_decode");
        e = idle(); e.alusrca = 1'b1; e.alusrcb = 2'b10;
        step(LW, 6'h0, 1'b0, 1'b0, e, "mid_memadr");
        e = idle(); e.mem_req = 1'b1; e.iord = 1'b1;
        step(LW, 6'h0, 1'b0, 1'b0, e, "mid_wait");
        step(LW, 6'h0, 1'b0, 1'b0, e, "mid_wait");
        do_reset();

        run_instr(6'b111111, 6'h0, 1'b0, 0, 0);
        do_reset();
        run_instr(RT, 6'b000000, 1'b0, 0, 0);
        do_reset();

        // Load whose data never arrives: four wait cycles, then timeout fault.
        step(LW, 6'h0, 1'b1, 1'b0, fetch_e(1'b1), "to_fetch");
        e = idle(); e.alusrcb = 2'b11;
        step(LW, 6'h0, rb(), 1'b0, e, "to_decode");
        e = idle(); e.alusrca = 1'b1; e.alusrcb = 2'b10;
        step(LW, 6'h0, rb(), 1'b0, e, "to_memadr");
        e = idle(); e.mem_req = 1'b1; e.iord = 1'b1;
        for (int i = 0; i < 4; i++) step(LW, 6'h0, 1'b0, rb(), e, "to_wait");
        for (int i = 0; i < 3; i++) step(LW, 6'h0, rb(), rb(), fault_e(2'b10), "to_fault");
        do_reset();

        // Long fetch: watchdog trips the first DUT; the second has none and then sees ori as illegal.
        for (int i = 0; i < 10; i++)
            step2(ORI, 6'h0, 1'b0, rb(), (i < 4) ? fetch_e(1'b0) : fault_e(2'b10),
                  fetch_e(1'b0), "long_fetch");
        step2(ORI, 6'h0, 1'b1, rb(), fault_e(2'b10), fetch_e(1'b1), "long_fetch_ready");
        e0 = idle(); e0.alusrcb = 2'b11;
        step2(ORI, 6'h0, rb(), rb(), fault_e(2'b10), e0, "ori_decode");
        for (int i = 0; i < 2; i++)
            step2(ORI, 6'h0, rb(), rb(), fault_e(2'b10), fault_e(2'b01), "ori_illegal");
        do_reset();
        run_instr(ANDI, 6'h0, 1'b0, 0, 0);

        @(posedge clk);
        #1;
        chk_end = 1'b1;
        @(posedge clk);
        #1;
        chk_end = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
